// File: rtl/game_pkg.sv
// Shared constants and types for the VGA shooter blocks: HID key codes,
// screen geometry, fire FSM states and the pixel coordinate type.
package game_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_FIRE  = 8'd44;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        READY,
        FIRE,
        COOLDOWN
    } fire_state_t;

    typedef logic [9:0] pix_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on the frame clock: frame_tick is high for exactly one
// Clk cycle after frame_clk goes from 0 to 1. Shared by enemy/projectile logic.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_clk_d_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d_q <= 1'b0;
        end else begin
            frame_clk_d_q <= frame_clk;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_d_q;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: key decode, per-frame clamped movement, sprite hit test
// and cooldown-gated fire FSM. Optional acceleration under PLAYER_ACCEL_EN.
module player_ctrl
    import game_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int WIDTH           = 16,
    parameter int HEIGHT          = 8,
    parameter int Y_TOP           = 436,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int STEP            = 2,
    parameter int MAX_STEP        = 6,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic [8*NUM_KEYS-1:0]   keycodes,
    input  pix_t                    DrawX,
    input  pix_t                    DrawY,
    input  logic                    shot_busy,
    output logic                    is_player,
    output pix_t                    player_X_Pos,
    output pix_t                    player_Y_Pos,
    output logic                    shot_fire,
    output pix_t                    shot_X,
    output logic                    fire_ready
);

    localparam int XR    = X_MAX - WIDTH + 1;
    localparam int X_RST = (X_MIN + X_MAX + 1 - WIDTH) / 2;
    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XR_S    = 11'(XR);

    logic frame_tick;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    logic left_p, right_p, fire_p;

    always_comb begin
        left_p  = 1'b0;
        right_p = 1'b0;
        fire_p  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keycodes[8*k +: 8] == KEY_LEFT)  left_p  = 1'b1;
            if (keycodes[8*k +: 8] == KEY_RIGHT) right_p = 1'b1;
            if (keycodes[8*k +: 8] == KEY_FIRE)  fire_p  = 1'b1;
        end
    end

    pix_t                x_q, x_d;
    logic                mv_left, mv_right;
    logic                clamp_l, clamp_r;
    logic signed [10:0]  x_ext, step_s, x_raw_l, x_raw_r;

    assign mv_left  = left_p & ~right_p;
    assign mv_right = right_p & ~left_p;
    assign x_ext    = signed'({1'b0, x_q});

`ifdef PLAYER_ACCEL_EN
    logic signed [10:0] speed_q, speed_d;
    logic [1:0]         dir_q, dir_d;

    // Speed only carries over when the previous tick moved the same way.
    assign dir_d  = {mv_right, mv_left};
    assign step_s = (dir_d != 2'b00 && dir_d == dir_q) ? speed_q : 11'(STEP);

    always_comb begin
        speed_d = 11'(STEP);
        if ((mv_left && !clamp_l) || (mv_right && !clamp_r)) begin
            speed_d = (step_s >= 11'(MAX_STEP)) ? 11'(MAX_STEP) : step_s + 11'sd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            speed_q <= 11'(STEP);
            dir_q   <= 2'b00;
        end else if (frame_tick) begin
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end
`else
    assign step_s = 11'(STEP);
`endif

    // Signed 11-bit math keeps X - step from wrapping below zero.
    assign x_raw_l = x_ext - step_s;
    assign x_raw_r = x_ext + step_s;
    assign clamp_l = (x_raw_l <= X_MIN_S);
    assign clamp_r = (x_raw_r >= XR_S);

    always_comb begin
        x_d = x_q;
        if (mv_left) begin
            x_d = clamp_l ? pix_t'(X_MIN) : x_raw_l[9:0];
        end else if (mv_right) begin
            x_d = clamp_r ? pix_t'(XR) : x_raw_r[9:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q <= pix_t'(X_RST);
        end else if (frame_tick) begin
            x_q <= x_d;
        end
    end

    fire_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            READY: begin
                if (frame_tick && fire_p && !shot_busy) state_d = FIRE;
            end
            FIRE: begin
                state_d = COOLDOWN;
                cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
            end
            COOLDOWN: begin
                // Going straight to FIRE at cnt = 0 keeps held-fire period at COOLDOWN_FRAMES.
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = (fire_p && !shot_busy) ? FIRE : READY;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [10:0] dx_ext, xq_ext;
    assign dx_ext = {1'b0, DrawX};
    assign xq_ext = {1'b0, x_q};

    assign is_player = (dx_ext >= xq_ext) && (dx_ext <= xq_ext + 11'(WIDTH - 1)) &&
                       (DrawY >= pix_t'(Y_TOP)) && (DrawY <= pix_t'(Y_TOP + HEIGHT - 1));

    assign player_X_Pos = x_q;
    assign player_Y_Pos = pix_t'(Y_TOP);
    assign shot_fire    = (state_q == FIRE);
    assign shot_X       = shot_fire ? x_q + pix_t'(WIDTH / 2) : '0;
    assign fire_ready   = (state_q == READY);

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: reset, hit test, clamped movement, fire
// cadence, busy gating, reset in cooldown; acceleration when PLAYER_ACCEL_EN.
module tb_player_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [15:0] keycodes = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        shot_busy = 1'b0;
  logic        is_player;
  logic [9:0]  player_X_Pos;
  logic [9:0]  player_Y_Pos;
  logic        shot_fire;
  logic [9:0]  shot_X;
  logic        fire_ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  player_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycodes     (keycodes),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .shot_busy    (shot_busy),
    .is_player    (is_player),
    .player_X_Pos (player_X_Pos),
    .player_Y_Pos (player_Y_Pos),
    .shot_fire    (shot_fire),
    .shot_X       (shot_X),
    .fire_ready   (fire_ready)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One frame: rising frame_clk, sample launch outputs one Clk later.
  task automatic do_tick(output logic pulse, output logic [9:0] sx);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    pulse = shot_fire;
    sx = shot_X;
    frame_clk = 1'b0;
    @(negedge Clk);
    check("fire_one_clk", {31'd0, shot_fire}, 32'd0);
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic exp);
    DrawX = x;
    DrawY = y;
    #1;
    check("is_player", {31'd0, is_player}, {31'd0, exp});
  endtask

  logic       p;
  logic [9:0] sx;
  int         npulse;

  initial begin
    // Reset and hit test
    do_reset();
    check("reset_fire_ready", {31'd0, fire_ready}, 32'd1);
    check("reset_x", {22'd0, player_X_Pos}, 32'd312);
    check("reset_shot_x", {22'd0, shot_X}, 32'd0);
    for (int i = 0; i < 3; i++) do_tick(p, sx);
    check("idle_x", {22'd0, player_X_Pos}, 32'd312);
    check("y_pos", {22'd0, player_Y_Pos}, 32'd436);
    probe(10'd312, 10'd436, 1'b1);
    probe(10'd327, 10'd443, 1'b1);
    probe(10'd328, 10'd436, 1'b0);
    probe(10'd312, 10'd444, 1'b0);
    probe(10'd311, 10'd440, 1'b0);
    probe(10'd320, 10'd435, 1'b0);
    check("idle_fire_ready", {31'd0, fire_ready}, 32'd1);

    // Right in slot 1, clamp at 624
    keycodes = {8'd79, 8'd0};
    for (int i = 1; i <= 200; i++) begin
      do_tick(p, sx);
      if (i == 1)   check("right_t1", {22'd0, player_X_Pos}, 32'd314);
      if (i == 155) check("right_t155", {22'd0, player_X_Pos}, 32'd622);
      if (i == 156) check("right_t156", {22'd0, player_X_Pos}, 32'd624);
    end
    check("right_t200", {22'd0, player_X_Pos}, 32'd624);
    probe(10'd639, 10'd436, 1'b1);

    // Left in slot 0, clamp at 0
    keycodes = '0;
    do_reset();
    keycodes = {8'd0, 8'd80};
    for (int i = 1; i <= 200; i++) begin
      do_tick(p, sx);
      if (i == 155) check("left_t155", {22'd0, player_X_Pos}, 32'd2);
      if (i == 156) check("left_t156", {22'd0, player_X_Pos}, 32'd0);
    end
    check("left_t200", {22'd0, player_X_Pos}, 32'd0);

    // Both directions pressed: hold
    keycodes = {8'd0, 8'd79};
    for (int i = 0; i < 5; i++) do_tick(p, sx);
    check("right_5", {22'd0, player_X_Pos}, 32'd10);
    keycodes = {8'd79, 8'd80};
    for (int i = 0; i < 10; i++) do_tick(p, sx);
    check("both_hold", {22'd0, player_X_Pos}, 32'd10);
    keycodes = {8'd80, 8'd79};
    for (int i = 0; i < 3; i++) do_tick(p, sx);
    check("both_swapped_hold", {22'd0, player_X_Pos}, 32'd10);

    // Held fire: pulses on ticks 1, 16, 31 at shot_X = 320
    keycodes = '0;
    do_reset();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd31);
    npulse = 0;
    keycodes = {8'd44, 8'd0};
    for (int i = 1; i <= 40; i++) begin
      do_tick(p, sx);
      if (p) begin
        npulse++;
        if (exp_q.size() == 0) begin
          check("fire_extra_pulse_tick", i, 32'd0);
        end else begin
          check("fire_pulse_tick", i, exp_q.pop_front());
        end
        check("fire_shot_x", {22'd0, sx}, 32'd320);
      end
    end
    check("fire_pulse_count", npulse, 32'd3);
    check("fire_missing_pulses", exp_q.size(), 32'd0);

    // Busy gating, then reset in cooldown
    keycodes = '0;
    do_reset();
    shot_busy = 1'b1;
    keycodes = {8'd0, 8'd44};
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      do_tick(p, sx);
      if (p) npulse++;
    end
    check("busy_no_pulse", npulse, 32'd0);
    check("busy_fire_ready", {31'd0, fire_ready}, 32'd1);
    shot_busy = 1'b0;
    do_tick(p, sx);
    check("unbusy_pulse", {31'd0, p}, 32'd1);
    check("unbusy_shot_x", {22'd0, sx}, 32'd320);
    check("cooldown_not_ready", {31'd0, fire_ready}, 32'd0);
    keycodes = {8'd79, 8'd44};
    for (int i = 0; i < 3; i++) do_tick(p, sx);
    check("move_in_cooldown", {22'd0, player_X_Pos}, 32'd318);
    check("cooldown_still", {31'd0, fire_ready}, 32'd0);
    keycodes = '0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_cd_fire_ready", {31'd0, fire_ready}, 32'd1);
    check("rst_cd_x", {22'd0, player_X_Pos}, 32'd312);
    Reset = 1'b0;

    // Reset landing on the FIRE cycle
    keycodes = {8'd0, 8'd44};
    @(negedge Clk);
    frame_clk = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_fire_no_pulse", {31'd0, shot_fire}, 32'd0);
    check("rst_fire_ready", {31'd0, fire_ready}, 32'd1);
    frame_clk = 1'b0;
    Reset = 1'b0;
    keycodes = '0;

`ifdef PLAYER_ACCEL_EN
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'd314);
    exp_q.push_back(32'd317);
    exp_q.push_back(32'd321);
    exp_q.push_back(32'd326);
    exp_q.push_back(32'd332);
    exp_q.push_back(32'd338);
    keycodes = {8'd0, 8'd79};
    for (int i = 0; i < 6; i++) begin
      do_tick(p, sx);
      check("accel_x", {22'd0, player_X_Pos}, exp_q.pop_front());
    end
    keycodes = '0;
    do_tick(p, sx);
    check("accel_release_hold", {22'd0, player_X_Pos}, 32'd338);
    keycodes = {8'd0, 8'd79};
    do_tick(p, sx);
    check("accel_restart", {22'd0, player_X_Pos}, 32'd340);
    keycodes = {8'd0, 8'd80};
    do_tick(p, sx);
    check("accel_reverse", {22'd0, player_X_Pos}, 32'd338);
    keycodes = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Parametrised next-generation player controller for the VGA shooter.
- Reads N simultaneous USB HID keycodes.
- Moves the player sprite horizontally once per frame, clamped to the screen bounds.
- Provides the pixel hit test for the colour mapper.
- Launches shots through a cooldown-gated fire FSM that handshakes with the projectile block.
- Sits between the keyboard interface and the colour mapper / projectile logic.

Parameters:
NUM_KEYS, 2, number of 8-bit keycode slots examined each frame
WIDTH, 16, sprite width in pixels
HEIGHT, 8, sprite height in pixels
Y_TOP, 436, fixed top row of the sprite
X_MIN, 0, leftmost legal pixel column
X_MAX, 639, rightmost legal pixel column
STEP, 2, pixels moved per frame (base speed)
MAX_STEP, 6, speed ceiling when acceleration is enabled
COOLDOWN_FRAMES, 15, frames between shots
KEY_LEFT / KEY_RIGHT / KEY_FIRE, 80 / 79 / 44, HID codes

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  vertical-sync-rate frame clock, asynchronous-looking level
keycodes  in  8*NUM_KEYS  packed keycode slots; slot k = bits [8k+7:8k]; 0 = empty
DrawX, DrawY  in  10 each  current VGA pixel
shot_busy  in  1  projectile in flight; blocks firing
is_player  out  1  current pixel lies inside the sprite
player_X_Pos  out  10  sprite left column
player_Y_Pos  out  10  constant Y_TOP
shot_fire  out  1  one-Clk launch pulse
shot_X  out  10  launch column; valid while shot_fire = 1
fire_ready  out  1  fire FSM in READY

Behaviour:
- Frame tick:
  - Register frame_clk.
  - frame_tick = frame_clk & ~frame_clk_d, asserted for exactly one Clk.
  - All movement and FSM updates occur only in frame_tick cycles; state holds otherwise.
- Key decode: a key is pressed if any slot equals its code. Slot order is irrelevant; duplicates are harmless.
- Movement on frame_tick, with XR = X_MAX - WIDTH + 1:
  - Left only: X = max(X - step, X_MIN).
  - Right only: X = min(X + step, XR).
  - Both pressed or neither pressed: X holds.
  - Arithmetic is 11-bit signed so X - step can never wrap below 0.
- Position timing: player_X_Pos is registered and updates the Clk after frame_tick.
- is_player:
  - Combinational, zero latency.
  - True iff X <= DrawX <= X+WIDTH-1 and Y_TOP <= DrawY <= Y_TOP+HEIGHT-1.
- Fire FSM states: READY, FIRE, COOLDOWN.
  - READY -> FIRE: on frame_tick with fire pressed and shot_busy = 0.
  - READY with fire pressed and shot_busy = 1: stay in READY, no pulse.
  - FIRE: lasts exactly one Clk.
    - shot_fire = 1.
    - shot_X = X + WIDTH/2, using X after the same tick's move.
    - Load cnt = COOLDOWN_FRAMES - 1.
    - Next state: COOLDOWN.
  - COOLDOWN: cnt decrements on each frame_tick; on a tick with cnt = 0 -> READY.
  - Holding fire auto-repeats every COOLDOWN_FRAMES frames, provided shot_busy is clear.
  - fire_ready = (state == READY).
- Simultaneous events: movement and fire on the same tick are both honoured; the shot uses the new X.
- Reset (any time, including mid-cooldown or during a FIRE cycle):
  - X = (X_MIN + X_MAX + 1 - WIDTH)/2 = 312.
  - state = READY, cnt = 0.
  - shot_fire = 0, shot_X = 0, frame_clk_d = 0.
  - fire_ready = 1 the cycle after reset.
- Parameter legality: WIDTH <= X_MAX - X_MIN + 1, STEP >= 1, COOLDOWN_FRAMES >= 1.

Optional Feature:
Macro PLAYER_ACCEL_EN.
- Defined:
  - A speed register starts at STEP.
  - Each consecutive tick in the same direction increments speed by 1, saturating at MAX_STEP.
  - Direction reversal, release or both-pressed resets speed to STEP.
  - Hitting a clamp resets speed to STEP.
  - Reset sets speed = STEP.
- Undefined: step is the constant STEP and MAX_STEP is ignored.

Decomposition:
- Package game_pkg:
  - KEY_LEFT, KEY_RIGHT and KEY_FIRE localparams.
  - SCREEN_W = 640 and SCREEN_H = 480.
  - typedef enum logic [1:0] {READY, FIRE, COOLDOWN} fire_state_t.
  - Pixel coordinate typedef logic [9:0] pix_t.
- One sub-module, frame_tick_gen:
  - Ports Clk, Reset, frame_clk -> frame_tick.
  - Reused by the enemy and projectile blocks.

Test Plan:
- Reset, then 3 ticks with no keys -> X = 312; is_player = 1 at (312,436) and (327,443), 0 at (328,436) and (312,444); fire_ready = 1.
- KEY_RIGHT held in slot 1 for 200 ticks -> X reaches 624 at tick 156 and stays 624; no wrap.
- KEY_LEFT held 200 ticks from 312 -> X = 0 at tick 156 and stays 0; with keys {80,79} in both slots for 10 ticks -> X unchanged.
- KEY_FIRE held 40 ticks, shot_busy = 0, X = 312:
  - Single-Clk shot_fire pulses on ticks 1, 16 and 31.
  - shot_X = 320 on each pulse.
  - No other pulses.
- KEY_FIRE with shot_busy = 1 for 5 ticks -> no pulse; shot_busy dropped -> pulse on the next tick. Reset asserted during COOLDOWN -> fire_ready = 1 and X = 312 the next cycle.
- With PLAYER_ACCEL_EN, KEY_RIGHT held from 312 -> X sequence 314, 317, 321, 326, 332, 338; release then press -> step returns to 2.
